// File: rtl/cpu_bus_seq_if.sv
// cpu_bus_seq_if: signal bundle between the core micro-sequencer, the bus
// cycle sequencer and the external memory bus.
//   Request side : req_valid, req_write, req_adr[15:0], req_wdata[7:0], req_ready
//   Response side: rsp_valid, rsp_rdata[7:0]
//   Timing       : tstate[1:0], mcyc_start
//   Memory bus   : adr[15:0], dout[7:0], dout_en, rd, wr, din[7:0]
// Modport slave is the sequencer. Modport master is everything around it
// (the core issuing requests plus the memory returning din).
interface cpu_bus_seq_if;
  logic        req_valid;
  logic        req_write;
  logic [15:0] req_adr;
  logic [7:0]  req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [1:0]  tstate;
  logic        mcyc_start;
  logic [15:0] adr;
  logic [7:0]  dout;
  logic        dout_en;
  logic        rd;
  logic        wr;
  logic [7:0]  din;

  modport slave (
    input  req_valid, req_write, req_adr, req_wdata, din,
    output req_ready, rsp_valid, rsp_rdata, tstate, mcyc_start,
           adr, dout, dout_en, rd, wr
  );

  modport master (
    output req_valid, req_write, req_adr, req_wdata, din,
    input  req_ready, rsp_valid, rsp_rdata, tstate, mcyc_start,
           adr, dout, dout_en, rd, wr
  );
endinterface

// File: rtl/cpu_bus_seq.sv
// cpu_bus_seq: turns one bus request per M-cycle into the four-T-cycle SM83
// bus protocol (T1..T4, one T-cycle per clk with ce high).
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high reset (effective regardless of ce)
//   ce    - T-cycle enable; low freezes all state and registered outputs
//   bus   - cpu_bus_seq_if.slave: request/response, T-state, memory bus
// The request is accepted on the ce clk that ends T4 and drives the next
// M-cycle. Bus outputs are registered so each edge loads the value for the
// T-state being entered; req_ready, tstate and mcyc_start are decoded from
// the T counter.
module cpu_bus_seq (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  cpu_bus_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    K_IDLE  = 2'd0,
    K_READ  = 2'd1,
    K_WRITE = 2'd2
  } kind_t;

  logic [1:0]  r_t;
  kind_t       r_kind;
  logic [7:0]  r_wdata;
  logic [15:0] r_adr;
  logic [7:0]  r_dout;
  logic        r_dout_en;
  logic        r_rd;
  logic        r_wr;
  logic        r_rsp_valid;
  logic [7:0]  r_rsp_rdata;

  logic        w_t4;

  assign w_t4 = (r_t == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_t         <= 2'd0;
      r_kind      <= K_IDLE;
      r_adr       <= 16'h0000;
      r_dout      <= 8'h00;
      r_dout_en   <= 1'b0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 8'h00;
    end else if (ce) begin
      r_t <= r_t + 2'd1;
      case (r_t)
        // End of T4: accept the next request and set up T1.
        2'd3: begin
          if (!bus.req_valid)     r_kind <= K_IDLE;
          else if (bus.req_write) r_kind <= K_WRITE;
          else                    r_kind <= K_READ;
          r_wdata <= bus.req_wdata;
          // An IDLE M-cycle leaves the previous address on the bus.
          if (bus.req_valid) r_adr <= bus.req_adr;
          r_rd        <= bus.req_valid & ~bus.req_write;
          r_wr        <= 1'b0;
          r_dout_en   <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
        // End of T1: a write starts driving data and raises wr for T2..T3.
        2'd0: begin
          if (r_kind == K_WRITE) begin
            r_dout    <= r_wdata;
            r_dout_en <= 1'b1;
            r_wr      <= 1'b1;
          end
        end
        // End of T3: read data is captured and rd drops before T4, so a
        // following write (wr from T2) can never overlap it.
        2'd2: begin
          if (r_kind == K_READ) begin
            r_rsp_rdata <= bus.din;
            r_rsp_valid <= 1'b1;
            r_rd        <= 1'b0;
          end
          if (r_kind == K_WRITE) begin
            r_wr <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.req_ready  = w_t4 & ce;
  assign bus.tstate     = r_t;
  assign bus.mcyc_start = (r_t == 2'd0);
  assign bus.adr        = r_adr;
  assign bus.dout       = r_dout;
  assign bus.dout_en    = r_dout_en;
  assign bus.rd         = r_rd;
  assign bus.wr         = r_wr;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_rdata  = r_rsp_rdata;

endmodule

// File: tb/tb_cpu_bus_seq.sv
// tb_cpu_bus_seq: directed bench for cpu_bus_seq. Read data expected at T4
// is queued when the read request is driven and popped when rsp_valid shows.
module tb_cpu_bus_seq;

  logic clk;
  logic reset;
  logic ce;

  cpu_bus_seq_if bus ();

  cpu_bus_seq dut (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  sb_q [$];
  logic [15:0] exp_adr   = 16'h0000;
  logic [7:0]  exp_rdata = 8'h00;
  logic [7:0]  exp_dout  = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one clk and sample 1 ns after the edge; check bus invariants.
  task automatic step();
    @(posedge clk);
    #1;
    chk("no_rd_wr_overlap", {31'd0, bus.rd & bus.wr}, 32'd0);
    chk("wr_implies_dout_en", {31'd0, bus.wr & ~bus.dout_en}, 32'd0);
  endtask

  // Called while in T4 with ce high. kind: 0 idle, 1 read, 2 write.
  task automatic mcycle(input int kind, input logic [15:0] a, input logic [7:0] d,
                        input logic [7:0] dv);
    bus.req_valid = (kind != 0);
    bus.req_write = (kind == 2);
    bus.req_adr   = a;
    bus.req_wdata = d;
    if (kind == 1) sb_q.push_back(dv);
    if (kind != 0) exp_adr = a;
    if (kind == 2) exp_dout = d;
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 0) begin
        bus.req_valid = 1'b0;
        bus.req_adr   = ~a;
        bus.req_wdata = ~d;
      end
      chk("tstate", {30'd0, bus.tstate}, k);
      chk("mcyc_start", {31'd0, bus.mcyc_start}, (k == 0));
      chk("req_ready", {31'd0, bus.req_ready}, (k == 3));
      chk("adr", {16'd0, bus.adr}, {16'd0, exp_adr});
      chk("rd", {31'd0, bus.rd}, (kind == 1 && k <= 2));
      chk("wr", {31'd0, bus.wr}, (kind == 2 && (k == 1 || k == 2)));
      chk("dout_en", {31'd0, bus.dout_en}, (kind == 2 && k >= 1));
      if (kind == 2 && k >= 1) chk("dout", {24'd0, bus.dout}, {24'd0, exp_dout});
      chk("rsp_valid", {31'd0, bus.rsp_valid}, (kind == 1 && k == 3));
      if (k == 2) bus.din = dv;
      if (k == 3) begin
        bus.din = ~dv;
        if (bus.rsp_valid) begin
          if (sb_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
          else exp_rdata = sb_q.pop_front();
        end
      end
      chk("rsp_rdata", {24'd0, bus.rsp_rdata}, {24'd0, exp_rdata});
    end
  endtask

  initial begin
    reset         = 1'b1;
    ce            = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_adr   = 16'h0000;
    bus.req_wdata = 8'h00;
    bus.din       = 8'h00;
    step();
    step();
    reset = 1'b0;

    // Reset state and four idle T-cycles.
    chk("rst_tstate", {30'd0, bus.tstate}, 32'd0);
    chk("rst_adr", {16'd0, bus.adr}, 32'h0000);
    chk("rst_dout", {24'd0, bus.dout}, 32'h00);
    chk("rst_dout_en", {31'd0, bus.dout_en}, 32'd0);
    chk("rst_rd", {31'd0, bus.rd}, 32'd0);
    chk("rst_wr", {31'd0, bus.wr}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", {24'd0, bus.rsp_rdata}, 32'h00);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst_mcyc_start", {31'd0, bus.mcyc_start}, 32'd1);
    for (int k = 1; k < 4; k++) begin
      step();
      chk("idle_tstate", {30'd0, bus.tstate}, k);
      chk("idle_req_ready", {31'd0, bus.req_ready}, (k == 3));
      chk("idle_adr", {16'd0, bus.adr}, 32'h0000);
      chk("idle_rd", {31'd0, bus.rd}, 32'd0);
      chk("idle_wr", {31'd0, bus.wr}, 32'd0);
    end

    // Single read, single write, then read/write back-to-back.
    mcycle(1, 16'hC123, 8'h00, 8'h5A);
    mcycle(2, 16'hFF80, 8'h3C, 8'h11);
    mcycle(1, 16'h0150, 8'h00, 8'h77);
    mcycle(2, 16'h0151, 8'h99, 8'h22);
    mcycle(0, 16'hDEAD, 8'hBE, 8'h33);

    // ce low in T4: req_ready drops and t holds.
    ce = 1'b0;
    #1;
    chk("ce0_req_ready", {31'd0, bus.req_ready}, 32'd0);
    step();
    chk("ce0_tstate_t4", {30'd0, bus.tstate}, 32'd3);
    ce = 1'b1;
    #1;
    chk("ce1_req_ready", {31'd0, bus.req_ready}, 32'd1);

    // Write with ce 1,0,0,1 during T2.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_adr   = 16'h2000;
    bus.req_wdata = 8'hA5;
    exp_adr       = 16'h2000;
    step();
    bus.req_valid = 1'b0;
    step();
    chk("cew_t2_tstate", {30'd0, bus.tstate}, 32'd1);
    chk("cew_t2_wr", {31'd0, bus.wr}, 32'd1);
    chk("cew_t2_dout", {24'd0, bus.dout}, 32'hA5);
    ce = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("cew_hold_tstate", {30'd0, bus.tstate}, 32'd1);
      chk("cew_hold_wr", {31'd0, bus.wr}, 32'd1);
      chk("cew_hold_dout", {24'd0, bus.dout}, 32'hA5);
      chk("cew_hold_adr", {16'd0, bus.adr}, 32'h2000);
    end
    ce = 1'b1;
    step();
    chk("cew_t3_tstate", {30'd0, bus.tstate}, 32'd2);
    chk("cew_t3_wr", {31'd0, bus.wr}, 32'd1);
    step();
    chk("cew_t4_tstate", {30'd0, bus.tstate}, 32'd3);
    chk("cew_t4_wr", {31'd0, bus.wr}, 32'd0);
    chk("cew_t4_dout_en", {31'd0, bus.dout_en}, 32'd1);

    // Reset in T2 of a read: strobes drop, no response, restart in idle T1.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_adr   = 16'h4444;
    step();
    bus.req_valid = 1'b0;
    chk("rr_t1_rd", {31'd0, bus.rd}, 32'd1);
    step();
    chk("rr_t2_rd", {31'd0, bus.rd}, 32'd1);
    reset   = 1'b1;
    bus.din = 8'hEE;
    step();
    reset = 1'b0;
    exp_adr   = 16'h0000;
    exp_rdata = 8'h00;
    chk("rr_rd", {31'd0, bus.rd}, 32'd0);
    chk("rr_tstate", {30'd0, bus.tstate}, 32'd0);
    chk("rr_adr", {16'd0, bus.adr}, 32'h0000);
    for (int k = 1; k < 4; k++) begin
      step();
      chk("rr_idle_tstate", {30'd0, bus.tstate}, k);
      chk("rr_idle_rd", {31'd0, bus.rd}, 32'd0);
      chk("rr_idle_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("rr_idle_rsp_rdata", {24'd0, bus.rsp_rdata}, 32'h00);
    end
    mcycle(1, 16'h8001, 8'h00, 8'hC7);

    // Reset with ce low during T2 of a write.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_adr   = 16'h1234;
    bus.req_wdata = 8'h55;
    step();
    bus.req_valid = 1'b0;
    step();
    chk("rc_t2_wr", {31'd0, bus.wr}, 32'd1);
    ce    = 1'b0;
    reset = 1'b1;
    step();
    ce    = 1'b1;
    reset = 1'b0;
    chk("rc_tstate", {30'd0, bus.tstate}, 32'd0);
    chk("rc_wr", {31'd0, bus.wr}, 32'd0);
    chk("rc_dout_en", {31'd0, bus.dout_en}, 32'd0);
    chk("rc_dout", {24'd0, bus.dout}, 32'h00);
    chk("rc_adr", {16'd0, bus.adr}, 32'h0000);
    chk("rc_rsp_rdata", {24'd0, bus.rsp_rdata}, 32'h00);
    exp_adr   = 16'h0000;
    exp_rdata = 8'h00;
    for (int k = 1; k < 4; k++) step();
    mcycle(0, 16'h5555, 8'h00, 8'h00);

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_bus_seq.md
# cpu_bus_seq

Bus cycle sequencer between the CPU core's micro-sequencer and the external memory bus. It converts one-per-M-cycle bus requests (read or write, 16-bit address, 8-bit data) into the four-T-cycle SM83 bus protocol. It drives address, data-out and read/write strobes, samples read data, and publishes the T-state so core and formal benches can index cycles.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock; one T-cycle per clk with ce high
- reset  in  1  synchronous, active-high reset
- ce  in  1  T-cycle enable; low freezes all state and outputs
- req_valid  in  1  core has a bus request for the next M-cycle
- req_write  in  1  1 = write, 0 = read
- req_adr  in  16  request address
- req_wdata  in  8  write data
- req_ready  out  1  request sampled on this clk (t == 3 and ce)
- rsp_valid  out  1  read data valid (T4 of a read M-cycle)
- rsp_rdata  out  8  captured read data
- tstate  out  2  current T-state, 0..3 = T1..T4
- mcyc_start  out  1  high during T1
- adr  out  16  bus address
- dout  out  8  bus write data
- dout_en  out  1  data bus driven by CPU
- rd  out  1  read strobe
- wr  out  1  write strobe
- din  in  8  bus read data

## Operation
- Counter t (2 bits) increments modulo 4 on each clk with ce=1; tstate = t. The counter wraps from 3 to 0 without a gap.
- Request acceptance: on a clk with ce=1 and t==3, the block latches req_valid, req_write, req_adr and req_wdata into the next-cycle registers. req_ready = (t==3) & ce, independent of req_valid.
- Each M-cycle is one of three kinds: READ, WRITE or IDLE. It is IDLE when req_valid was 0 at acceptance.
- READ: adr = latched address T1..T4. rd = 1 in T1..T3. din is captured into rsp_rdata on the ce clk ending T3. rsp_valid = 1 throughout T4.
- WRITE: adr = latched address T1..T4. dout = latched data and dout_en = 1 in T2..T4. wr = 1 in T2..T3. rsp_valid = 0.
- IDLE: adr holds the previous M-cycle's address. rd = wr = dout_en = 0. dout holds its value.
- rsp_rdata holds its value until the next READ captures new data.
- All outputs are registered except req_ready, tstate and mcyc_start. Those three are decoded from t and ce.
- Address arithmetic: none. The address passes through unmodified over 16 bits.

## Timing
- Reset values: t=0, adr=16'h0000, dout=8'h00, dout_en=0, rd=0, wr=0, rsp_valid=0, rsp_rdata=8'h00, next-cycle kind = IDLE.
- The first M-cycle after reset is IDLE. The first request is sampled at the first T4.
- Request-to-bus latency: a request sampled at T4 of M-cycle n appears on adr at T1 of M-cycle n+1, one clk later with ce=1.
- Read latency: data sampled at the end of T3 of n+1; rsp_valid during T4 of n+1.
- Back-to-back: a READ followed by a WRITE gives rd falling at T3→T4 and wr rising at T2 of the next M-cycle. The two strobes never overlap.
- ce low: t, strobes, adr, dout and rsp_valid all hold. req_ready = 0. din is not sampled.
- Reset mid-M-cycle: all strobes are low on the next clk. A pending response is dropped and a pending request discarded. The sequence restarts at T1 IDLE.
- reset with ce=0: reset still takes effect.
- Invariant: rd & wr is never 1. wr implies dout_en.

## Test plan
- Reset then 4 ce clks with req_valid=0: adr=0000, rd=wr=0, tstate 0,1,2,3, and req_ready high only on tstate 3.
- READ 0xC123 sampled at T4 with din=0x5A at T3: adr=C123 for T1..T4, rd high for T1..T3, rsp_valid high in T4, rsp_rdata=0x5A.
- WRITE 0xFF80 with data 0x3C: adr=FF80 for T1..T4, dout=3C with dout_en high for T2..T4, wr high for T2..T3, rsp_valid=0.
- READ 0x0150 then WRITE 0x0151/0x99 back-to-back: no clk has rd & wr. adr switches 0150→0151 exactly at T1. rsp_rdata is held through the write.
- ce toggling 1,0,0,1 during T2 of a WRITE: tstate, wr and dout stay stable while ce=0, then advance to T3. No extra T-state is added.
- reset asserted in T2 of a READ: rd=0 next clk, tstate=0, no rsp_valid pulse, and the following M-cycle is IDLE.
